// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - radix-2 shift-add unsigned multiplier with IDLE/RUN/DONE control
// Optional zero-operand shortcut: define SEQ_MULTIPLIER_ZERO_SKIP_EN.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Busy,
    output logic                 Done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_sum;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            last_step;
    logic            zero_op;

    // Decode of the current step: acceptance window, final step, next partial sum
    always_comb begin
        accept    = Start && ((state == IDLE) || (state == DONE));
        last_step = (state == RUN) && (cnt == CW'(WIDTH - 1));
        acc_sum   = mplier[0] ? (acc + mcand) : acc;
`ifdef SEQ_MULTIPLIER_ZERO_SKIP_EN
        zero_op   = (Multiplicand == '0) || (Multiplier == '0);
`else
        zero_op   = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: Start is only honoured outside RUN, DONE lasts a single cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Start) state_nxt = zero_op ? DONE : RUN;
            end
            RUN: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                if (Start) state_nxt = zero_op ? DONE : RUN;
                else       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, one shift-add step per RUN cycle,
    // Product only updates when a result completes
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            Product <= '0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, Multiplicand};
            mplier <= Multiplier;
            acc    <= '0;
            cnt    <= '0;
            if (zero_op) Product <= '0;
        end else if (state == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last_step) Product <= acc_sum;
        end
    end

    // Status outputs decoded from state so they can never overlap
    always_comb begin
        Busy = (state == RUN);
        Done = (state == DONE);
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier against a transaction-level model
module tb_seq_multiplier;

    localparam int W  = 4;
    localparam int PW = 2 * W;
`ifdef SEQ_MULTIPLIER_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = W + 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] product;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(W)) dut (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .Start        (start),
        .Multiplicand (a),
        .Multiplier   (b),
        .Product      (product),
        .Busy         (busy),
        .Done         (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted request yields A*B exactly W edges later
    bit            m_pend      = 0;
    bit            m_zero;
    int            m_edge      = 0;
    int            m_done_edge = 0;
    logic [PW-1:0] m_res       = '0;
    logic [PW-1:0] e_product   = '0;
    bit            e_busy      = 0;
    bit            e_done      = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend    = 0;
            e_product = '0;
            e_busy    = 0;
            e_done    = 0;
            m_edge    = 0;
        end else begin
            m_edge++;
            e_done = 0;
            if (m_pend) begin
                if (m_edge == m_done_edge) begin
                    e_product = m_res;
                    e_done    = 1;
                    m_pend    = 0;
                end
            end else if (start) begin
                m_res  = PW'(a) * PW'(b);
                m_zero = 0;
`ifdef SEQ_MULTIPLIER_ZERO_SKIP_EN
                m_zero = (a == 0) || (b == 0);
`endif
                if (m_zero) begin
                    e_product = '0;
                    e_done    = 1;
                end else begin
                    m_pend      = 1;
                    m_done_edge = m_edge + W;
                end
            end
            e_busy = m_pend;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("product", 32'(product), 32'(e_product));
            check("busy_done_overlap", 32'(busy && done), 32'd0);
        end
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                         input logic [PW-1:0] exp_p, input int exp_lat,
                         input string tag, input bit scramble);
        int n;
        int nb;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_b;
        @(posedge clk);
        n    = 1;
        nb   = 0;
        seen = 0;
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            a = ~ta;
            b = ~tb_b;
        end
        while (n <= 20) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) nb++;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, seen ? 32'(n) : 32'd0, 32'(exp_lat));
        check({tag, "_product"}, 32'(product), 32'(exp_p));
        check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_lat - 1));
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 1;
        while (n <= 20 && !done) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_product", 32'(product), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Start on the first edge after release is accepted
        do_op(4'b1000, 4'b0010, 8'h10, W + 1, "a8b2", 0);
        do_op(4'b1111, 4'b1111, 8'hE1, W + 1, "max", 0);
        do_op(4'b0110, 4'b0000, 8'h00, ZLAT, "zero_b", 0);
        do_op(4'b0000, 4'b0101, 8'h00, ZLAT, "zero_a", 0);
        do_op(4'b1011, 4'b0110, 8'h42, W + 1, "scramble", 1);

        // Back-to-back with Start held high; operand change during RUN ignored
        @(negedge clk);
        start = 1'b1;
        a = 4'd7;
        b = 4'd3;
        @(posedge clk);
        @(negedge clk);
        a = 4'd9;
        b = 4'd3;
        wait_done("b2b1", n);
        check("b2b1_latency", 32'(n), 32'(W + 1));
        check("b2b1_product", 32'(product), 32'd21);
        @(posedge clk);
        @(negedge clk);
        check("b2b_rerun_busy", 32'(busy), 32'd1);
        wait_done("b2b2", n);
        start = 1'b0;
        check("b2b2_latency", 32'(n), 32'(W + 1));
        check("b2b2_product", 32'(product), 32'd27);

        // Reset during RUN cycle 2 of 15*4
        @(negedge clk);
        start = 1'b1;
        a = 4'd15;
        b = 4'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_product", 32'(product), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("postrst_no_done", 32'(done), 32'd0);
            check("postrst_idle", 32'(busy), 32'd0);
        end
        do_op(4'd9, 4'd3, 8'd27, W + 1, "postrst", 0);

        // Randomized traffic checked by the compare process
        repeat (400) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
